imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader sitting directly upstream of the single-cycle MIPS core's instruction memory. It accepts a word stream over a valid/ready handshake and writes it into consecutive word addresses from 0. It then verifies a trailing XOR checksum and only then releases the core by asserting `cpu_run`, which the top level ANDs into `PCEnable`. Addresses are word indices, consistent with the PC incrementing by 1.

## Interface
Parameters:
- `ADDR_W`, 8, instruction memory address width in words; depth = 2**ADDR_W.
- `DATA_W`, 32, instruction word width.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request to begin a load; `len` sampled in the same cycle.
- `len`  in  ADDR_W+1  number of program words to load (0 .. 2**ADDR_W).
- `in_valid`  in  1  producer has a word on `in_data`.
- `in_ready`  out  1  loader accepts a word this cycle.
- `in_data`  in  DATA_W  program word, or checksum word after `len` words.
- `imem_we`  out  1  instruction memory write strobe.
- `imem_addr`  out  ADDR_W  write word address.
- `imem_wdata`  out  DATA_W  write data.
- `cpu_run`  out  1  core may fetch/advance PC.
- `busy`  out  1  load in progress (LOAD or CHECK).
- `err`  out  1  load failed (bad length or checksum mismatch); sticky until next `start` or reset.

## Operation
- Beat = cycle with `in_valid && in_ready`.
- State machine, all transitions on the clock edge:
  - IDLE: `in_ready=0`. On `start`, if `len > 2**ADDR_W`, go to ERROR. If `len == 0`, go to CHECK. Otherwise go to LOAD. On any `start`, clear `cnt`, `sum` and `err`, and latch `len`.
  - LOAD: `in_ready=1`. Each beat writes `in_data` to address `cnt`, sets `sum ^= in_data` and increments `cnt`. The beat with `cnt == len-1` moves to CHECK.
  - CHECK: `in_ready=1`. On a beat, go to RUN if `in_data == sum`, else go to ERROR. The checksum word is never written to memory.
  - RUN: `cpu_run=1`, `in_ready=0`.
  - ERROR: `err=1`, `cpu_run=0`, `in_ready=0`.
- `start` is ignored in LOAD and CHECK.
- `start` in RUN or ERROR restarts the load exactly as from IDLE. `cpu_run` falls on the next edge.
- `in_valid` without `in_ready` has no effect. The producer holds `in_data` until the beat.
- `cnt` is ADDR_W+1 bits, so `len == 2**ADDR_W` loads every address without wrap. Address 2**ADDR_W is never driven.
- Arithmetic: `sum` is a DATA_W-bit XOR with seed 0. Compares are unsigned.

## Timing
- All outputs are registered.
- Reset values: `in_ready=0`, `imem_we=0`, `imem_addr=0`, `imem_wdata=0`, `cpu_run=0`, `busy=0`, `err=0`, state IDLE, `cnt=0`, `sum=0`.
- Reset asserted mid-load aborts at once. Memory contents are undefined and `cpu_run` stays 0.
- Write latency: a beat at edge N gives `imem_we=1` with the matching address and data during cycle N+1. `imem_we` is high for exactly one cycle per data beat.
- `in_ready` rises the cycle after `start` and falls the cycle after the last (checksum) beat.
- `cpu_run` rises the cycle after a matching checksum beat. That is at least one cycle after the final `imem_we`, so no fetch races a write.
- Sustained throughput: 1 word/cycle while `in_valid` is held high. Total load time with back-to-back data = `len` + 2 cycles from `start` to `cpu_run`.
- `busy` equals state in {LOAD, CHECK}, registered with the state.

## Structure
- Shared package `loader_pkg`:
  - state enum {IDLE, LOAD, CHECK, RUN, ERROR}.
  - `CSUM_SEED = 0`.
- Single module, no sub-module: the FSM, counter and XOR accumulator are tightly coupled.
- Top-level integration: `PCEnable_core = PCEnable & cpu_run`. Instruction memory gains a write port driven by `imem_we`/`imem_addr`/`imem_wdata`.

## Test plan
- Reset mid-LOAD after 2 of 4 words → all outputs return to reset values immediately; a fresh `start` reloads correctly.
- `start`, `len=3`, words 0x20080005, 0x21290001, 0x08000000, checksum = XOR of all three → writes to addresses 0, 1, 2; `cpu_run=1` at cycle 5 after `start`; `err=0`.
- Same stream with the checksum bit 0 flipped → no `cpu_run`; `err=1`; memory writes still occurred; `in_ready=0` afterwards.
- `len=0`, then checksum 0x00000000 → no `imem_we` and `cpu_run=1`. Repeat with checksum 0x1 → `err=1`.
- `len=2**ADDR_W+1` → ERROR the next cycle, `in_ready` never asserts. `len=2**ADDR_W` with random data and gaps in `in_valid` → last address written is 2**ADDR_W-1, no wrap to 0.
- `start` pulsed during LOAD is ignored. `start` in RUN → `cpu_run` falls the next cycle and a second program loads over the first.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and constants for the instruction memory loader
//
// Contents:
//   state_t   : loader FSM states
//   CSUM_SEED : initial value of the running XOR checksum
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_RUN,
        ST_ERROR
    } state_t;

    localparam int unsigned CSUM_SEED = 0;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - valid/ready word stream feeding the instruction memory loader
//
// Signals:
//   in_valid : producer has a word on in_data
//   in_ready : loader accepts a word this cycle
//   in_data  : program word, or the checksum word after the last program word
// Modports:
//   master : producer side
//   slave  : loader side
interface imem_loader_if #(
    parameter int DATA_W = 32
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader that streams a program into instruction memory and gates the core
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle load request; len sampled in the same cycle
//   len        : number of program words (0 .. 2**ADDR_W)
//   in_s       : word stream (slave side); program words then one XOR checksum word
//   imem_we    : instruction memory write strobe
//   imem_addr  : write word address
//   imem_wdata : write data
//   cpu_run    : core may fetch/advance PC
//   busy       : load in progress (LOAD or CHECK)
//   err        : bad length or checksum mismatch; sticky until next start or reset
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    imem_loader_if.slave      in_s,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

    state_t            state;
    state_t            state_n;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   len_q;
    logic [DATA_W-1:0] sum;
    logic              ready_q;
    logic              beat;
    logic              load_beat;
    logic              last_word;
    logic              restart;

    assign in_s.in_ready = ready_q;
    assign beat          = in_s.in_valid && ready_q;
    assign load_beat     = beat && (state == ST_LOAD);
    // cnt is one bit wider than the address so len == DEPTH terminates without wrapping.
    assign last_word     = ((cnt + ONE) == len_q);
    // start only takes effect outside an active load.
    assign restart       = start && (state == ST_IDLE || state == ST_RUN || state == ST_ERROR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE, ST_RUN, ST_ERROR: begin
                if (start) begin
                    if (len > DEPTH) begin
                        state_n = ST_ERROR;
                    end else if (len == '0) begin
                        state_n = ST_CHECK;
                    end else begin
                        state_n = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (load_beat && last_word) begin
                    state_n = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (beat) begin
                    state_n = (in_s.in_data == sum) ? ST_RUN : ST_ERROR;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Counter, checksum accumulator and latched length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            sum   <= DATA_W'(CSUM_SEED);
            len_q <= '0;
        end else if (restart) begin
            cnt   <= '0;
            sum   <= DATA_W'(CSUM_SEED);
            len_q <= len;
        end else if (load_beat) begin
            cnt   <= cnt + ONE;
            sum   <= sum ^ in_s.in_data;
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q    <= 1'b0;
            busy       <= 1'b0;
            cpu_run    <= 1'b0;
            err        <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            ready_q <= (state_n == ST_LOAD) || (state_n == ST_CHECK);
            busy    <= (state_n == ST_LOAD) || (state_n == ST_CHECK);
            cpu_run <= (state_n == ST_RUN);
            err     <= (state_n == ST_ERROR);
            imem_we <= load_beat;
            if (load_beat) begin
                imem_addr  <= cnt[ADDR_W-1:0];
                imem_wdata <= in_s.in_data;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader against a beat-counting reference model
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   len   = '0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              cpu_run;
    logic              busy;
    logic              err;

    imem_loader_if #(.DATA_W(DATA_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .in_s       (bus),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_run    (cpu_run),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a load is "words still owed" (program words plus one checksum).
    int          m_remaining;
    int          m_idx;
    logic        m_ready, m_run, m_err, m_we;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata, m_sum;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_remaining <= 0; m_idx <= 0; m_ready <= 0; m_run <= 0; m_err <= 0;
            m_we <= 0; m_addr <= 0; m_wdata <= 0; m_sum <= 0;
        end else begin : step
            automatic int          rem  = m_remaining;
            automatic int          idx  = m_idx;
            automatic logic [31:0] s    = m_sum;
            automatic logic        run  = m_run;
            automatic logic        bad  = m_err;
            automatic logic        we   = 1'b0;
            if (rem > 0) begin
                if (bus.in_valid && m_ready) begin
                    if (rem > 1) begin
                        we = 1'b1;
                        m_addr  <= idx[7:0];
                        m_wdata <= bus.in_data;
                        s   = s ^ bus.in_data;
                        idx = idx + 1;
                    end else begin
                        run = (bus.in_data == s);
                        bad = !run;
                    end
                    rem = rem - 1;
                end
            end else if (start) begin
                run = 0; bad = 0; s = 0; idx = 0;
                if (int'(len) > DEPTH) bad = 1;
                else rem = int'(len) + 1;
            end
            m_remaining <= rem; m_idx <= idx; m_sum <= s;
            m_run <= run; m_err <= bad; m_we <= we;
            m_ready <= (rem > 0);
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("in_ready", bus.in_ready, m_ready);
            chk("busy", busy, m_ready);
            chk("cpu_run", cpu_run, m_run);
            chk("err", err, m_err);
            chk("imem_we", imem_we, m_we);
            if (m_we) begin
                chk("imem_addr", imem_addr, m_addr);
                chk("imem_wdata", imem_wdata, m_wdata);
            end
        end
    end

    // Capture of what the DUT actually wrote.
    logic [31:0] dmem [DEPTH];
    int          wr_cnt    = 0;
    logic [7:0]  last_addr = '0;
    always @(posedge clk) begin
        if (rst_n && imem_we) begin
            dmem[imem_addr] <= imem_wdata;
            wr_cnt          <= wr_cnt + 1;
            last_addr       <= imem_addr;
        end
    end

    logic [31:0] prog [DEPTH];

    task automatic do_start(input int l);
        start = 1'b1;
        len   = l[ADDR_W:0];
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] w, input int gap);
        bit seen = 1'b0;
        if (gap > 0) repeat ($urandom_range(0, gap)) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        for (int i = 0; i < 50 && !seen; i++) begin
            seen = bus.in_ready;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("send_accept", seen, 1);
    endtask

    task automatic load_body(input int n, input bit corrupt, input int gap);
        logic [31:0] s = 0;
        for (int i = 0; i < n; i++) begin
            prog[i] = $urandom;
            s = s ^ prog[i];
            send(prog[i], gap);
        end
        send(corrupt ? (s ^ 32'h1) : s, gap);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_mem(input int n);
        for (int i = 0; i < n; i++) chk("mem", dmem[i], prog[i]);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_imem_we"}, imem_we, 0);
        chk({tag, "_imem_addr"}, imem_addr, 0);
        chk({tag, "_imem_wdata"}, imem_wdata, 0);
        chk({tag, "_cpu_run"}, cpu_run, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        bit bad;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // Power-on reset.
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // Reset mid-load after 2 of 4 words, then a clean reload.
        do_start(4);
        send(32'h1111_0000, 0);
        send(32'h2222_0000, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start(4);
        load_body(4, 1'b0, 1);
        check_mem(4);
        chk("reload_run", cpu_run, 1);

        // Directed three-word program, back-to-back: cpu_run in cycle 5 after start.
        base = wr_cnt;
        do_start(3);
        send(32'h2008_0005, 0);
        send(32'h2129_0001, 0);
        send(32'h0800_0000, 0);
        send(32'h0921_0004, 0);
        chk("run_cycle5", cpu_run, 1);
        chk("run_cycle5_err", err, 0);
        @(negedge clk);
        chk("dir_mem0", dmem[0], 32'h2008_0005);
        chk("dir_mem1", dmem[1], 32'h2129_0001);
        chk("dir_mem2", dmem[2], 32'h0800_0000);
        chk("dir_writes", wr_cnt - base, 3);

        // Same stream with checksum bit 0 flipped.
        base = wr_cnt;
        do_start(3);
        send(32'h2008_0005, 0);
        send(32'h2129_0001, 0);
        send(32'h0800_0000, 0);
        send(32'h0921_0005, 0);
        chk("badcs_err", err, 1);
        chk("badcs_run", cpu_run, 0);
        @(negedge clk);
        chk("badcs_ready", bus.in_ready, 0);
        chk("badcs_writes", wr_cnt - base, 3);

        // Empty program.
        base = wr_cnt;
        do_start(0);
        send(32'h0, 0);
        chk("len0_run", cpu_run, 1);
        chk("len0_writes", wr_cnt - base, 0);
        do_start(0);
        send(32'h1, 0);
        chk("len0_err", err, 1);

        // Over-length request.
        do_start(DEPTH + 1);
        chk("overlen_err", err, 1);
        chk("overlen_ready", bus.in_ready, 0);
        repeat (4) @(negedge clk);

        // Full-depth program with gaps in in_valid: no wrap past the last address.
        base = wr_cnt;
        do_start(DEPTH);
        load_body(DEPTH, 1'b0, 2);
        chk("full_run", cpu_run, 1);
        chk("full_writes", wr_cnt - base, DEPTH);
        chk("full_last_addr", last_addr, DEPTH - 1);
        check_mem(DEPTH);

        // start pulsed mid-load is ignored.
        do_start(5);
        prog[0] = 32'hA5A5_0001;
        prog[1] = 32'hA5A5_0002;
        prog[2] = 32'hA5A5_0003;
        prog[3] = 32'hA5A5_0004;
        prog[4] = 32'hA5A5_0005;
        send(prog[0], 0);
        send(prog[1], 0);
        start = 1'b1;
        len   = 9'd1;
        @(negedge clk);
        start = 1'b0;
        send(prog[2], 0);
        send(prog[3], 0);
        send(prog[4], 0);
        send(32'hA5A5_0001, 0);
        chk("ignore_start_run", cpu_run, 1);
        @(negedge clk);
        check_mem(5);

        // Restart from RUN: cpu_run drops next cycle, second program overwrites.
        do_start(3);
        chk("restart_run_falls", cpu_run, 0);
        load_body(3, 1'b0, 1);
        chk("restart_run", cpu_run, 1);
        check_mem(3);

        // Random programs, some with a corrupted checksum.
        for (int t = 0; t < 8; t++) begin
            n   = $urandom_range(1, 20);
            bad = 1'($urandom_range(0, 1));
            do_start(n);
            load_body(n, bad, 3);
            chk("rand_err", err, bad);
            chk("rand_run", cpu_run, !bad);
            check_mem(n);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
